// File: rtl/and3_sweep_pkg.sv
// Shared types, widths and vector ordering for the AND3 sweep sequencer.
// Gray ordering is selected by the AND3_SWEEP_GRAY_EN macro in the vecgen.
package and3_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        FINISH
    } state_e;

    localparam int VEC_W = 3;
    localparam int CNT_W = 4;
    localparam int SET_W = 8;

    function automatic logic [VEC_W-1:0] idx_to_vec(
        input logic [VEC_W-1:0] idx,
        input logic             gray
    );
        return gray ? (idx ^ (idx >> 1)) : idx;
    endfunction

endpackage

// File: rtl/and3_sweep_vecgen.sv
// Sequence index register and registered vector driven onto {A3,A2,A1}.
// AND3_SWEEP_GRAY_EN defined: Gray order; undefined: binary order.
import and3_sweep_pkg::*;

module and3_sweep_vecgen (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    input  logic             drv,
    output logic [VEC_W-1:0] idx,
    output logic [VEC_W-1:0] vec
);

`ifdef AND3_SWEEP_GRAY_EN
    localparam logic GRAY = 1'b1;
`else
    localparam logic GRAY = 1'b0;
`endif

    logic [VEC_W-1:0] idx_q, idx_d;
    logic [VEC_W-1:0] vec_q, vec_d;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (adv) begin
            idx_d = idx_q + 3'd1;
        end
        // Vector is registered one step ahead so it is stable for the whole window
        vec_d = drv ? idx_to_vec(idx_d, GRAY) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            vec_q <= '0;
        end else begin
            idx_q <= idx_d;
            vec_q <= vec_d;
        end
    end

    assign idx = idx_q;
    assign vec = vec_q;

endmodule

// File: rtl/and3_sweep_ctrl.sv
// Sweeps all 3-input vectors of a cell under test and checks Z against TRUTH.
// Vector ordering follows AND3_SWEEP_GRAY_EN (see and3_sweep_vecgen).
import and3_sweep_pkg::*;

module and3_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  TRUTH         = 8'b1000_0000,
    parameter int unsigned PASSES        = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             Z,
    output logic             A1,
    output logic             A2,
    output logic             A3,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [VEC_W-1:0] FAIL_VEC
);

    state_e             state_q, state_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [CNT_W-1:0]   pass_q, pass_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [VEC_W-1:0]   fvec_q, fvec_d;
    logic               ok_q, ok_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               vg_clr, vg_adv;
    logic [VEC_W-1:0]   idx, vec;
    logic               miss;

    and3_sweep_vecgen u_vecgen (
        .clk (CLK),
        .rst (RST),
        .clr (vg_clr),
        .adv (vg_adv),
        .drv (busy_d),
        .idx (idx),
        .vec (vec)
    );

    assign miss = !(Z === TRUTH[vec]);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fvec_d   = fvec_q;
        ok_d     = ok_q;
        vg_clr   = 1'b0;
        vg_adv   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                    pass_d   = '0;
                    err_d    = '0;
                    fvec_d   = '0;
                    ok_d     = 1'b0;
                    vg_clr   = 1'b1;
                end
            end
            SETTLE: begin
                settle_d = settle_q + 8'd1;
                if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    state_d  = SAMPLE;
                end
            end
            SAMPLE: begin
                if (miss) begin
                    if (err_q != 4'hF) begin
                        err_d = err_q + 4'd1;
                    end
                    if (err_q == '0) begin
                        fvec_d = vec;
                    end
                end
                if (idx != 3'd7) begin
                    vg_adv  = 1'b1;
                    state_d = SETTLE;
                end else if (pass_q != CNT_W'(PASSES - 1)) begin
                    vg_clr  = 1'b1;
                    pass_d  = pass_q + 4'd1;
                    state_d = SETTLE;
                end else begin
                    // PASS must already be valid in the DONE cycle
                    ok_d    = (err_d == '0);
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            settle_q <= '0;
            pass_q   <= '0;
            err_q    <= '0;
            fvec_q   <= '0;
            ok_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fvec_q   <= fvec_d;
            ok_q     <= ok_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign A1       = vec[0];
    assign A2       = vec[1];
    assign A3       = vec[2];
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign PASS     = ok_q;
    assign ERR_CNT  = err_q;
    assign FAIL_VEC = fvec_q;

endmodule

// File: tb/tb_and3_sweep_ctrl.sv
// Scoreboard bench: two sequencers (1 and 3 passes) sweep a table-driven cell model.
// Expected results come from a sweep model built from the cell truth tables.
module tb_and3_sweep_ctrl;

    localparam int         S  = 2;
    localparam logic [7:0] TT = 8'b1000_0000;

    typedef struct {
        int done_cyc;
        int err;
        int fv;
        int pass;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] f_tbl;
    int         cyc;
    int         n_chk;
    int         n_fail;
    int         bad [2];
    exp_t       sb0[$];
    exp_t       sb1[$];

    logic       z0, z1;
    logic       a1_0, a2_0, a3_0, a1_1, a2_1, a3_1;
    logic       busy [2];
    logic       done [2];
    logic       ps   [2];
    logic [3:0] err  [2];
    logic [2:0] fv   [2];
    logic [2:0] a    [2];

    assign a[0] = {a3_0, a2_0, a1_0};
    assign a[1] = {a3_1, a2_1, a1_1};
    assign z0   = f_tbl[a[0]];
    assign z1   = f_tbl[a[1]];

    and3_sweep_ctrl #(.SETTLE_CYCLES(S), .TRUTH(TT), .PASSES(1)) u_p1 (
        .CLK(clk), .RST(rst), .START(start), .Z(z0),
        .A1(a1_0), .A2(a2_0), .A3(a3_0),
        .BUSY(busy[0]), .DONE(done[0]), .PASS(ps[0]),
        .ERR_CNT(err[0]), .FAIL_VEC(fv[0])
    );

    and3_sweep_ctrl #(.SETTLE_CYCLES(S), .TRUTH(TT), .PASSES(3)) u_p3 (
        .CLK(clk), .RST(rst), .START(start), .Z(z1),
        .A1(a1_1), .A2(a2_1), .A3(a3_1),
        .BUSY(busy[1]), .DONE(done[1]), .PASS(ps[1]),
        .ERR_CNT(err[1]), .FAIL_VEC(fv[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] ord(input int i);
        logic [2:0] v;
        v = 3'(i);
`ifdef AND3_SWEEP_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    function automatic int npass(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Result of sweeping a cell whose function is table f
    function automatic exp_t model(input logic [7:0] f, input int passes, input int st);
        exp_t e;
        int   m;
        int   fvv;
        logic [2:0] v;
        m   = 0;
        fvv = 0;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < 8; i++) begin
                v = ord(i);
                if (f[v] != TT[v]) begin
                    if (m == 0) fvv = int'(v);
                    if (m < 15) m++;
                end
            end
        end
        e.done_cyc = st + passes * 8 * (S + 1) + 1;
        e.err      = m;
        e.fv       = fvv;
        e.pass     = (m == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic mon(input int d);
        exp_t h;
        int   n;
        int   k;
        int   len;
        if (rst) begin
            bad[d] = 0;
            return;
        end
        n = (d == 0) ? sb0.size() : sb1.size();
        if (n == 0) begin
            if (busy[d]) check($sformatf("spurious_busy%0d", d), 1, 0);
            if (done[d]) check($sformatf("spurious_done%0d", d), 1, 0);
            return;
        end
        h   = (d == 0) ? sb0[0] : sb1[0];
        len = npass(d) * 8 * (S + 1);
        if (busy[d]) begin
            k = cyc - (h.done_cyc - len - 1);
            if (k < 1 || k > len || a[d] != ord(((k - 1) / (S + 1)) % 8))
                bad[d]++;
        end else if (a[d] != 3'd0) begin
            bad[d]++;
        end
        if (done[d]) begin
            check($sformatf("done_cycle%0d", d), cyc, h.done_cyc);
            check($sformatf("err_cnt%0d", d), int'(err[d]), h.err);
            check($sformatf("fail_vec%0d", d), int'(fv[d]), h.fv);
            check($sformatf("pass%0d", d), int'(ps[d]), h.pass);
            check($sformatf("vec_seq%0d", d), bad[d], 0);
            bad[d] = 0;
            if (d == 0) void'(sb0.pop_front());
            else        void'(sb1.pop_front());
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon(d);
    end

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_a%0d", tag, d), int'(a[d]), 0);
            check($sformatf("%s_busy%0d", tag, d), int'(busy[d]), 0);
            check($sformatf("%s_done%0d", tag, d), int'(done[d]), 0);
            check($sformatf("%s_pass%0d", tag, d), int'(ps[d]), 0);
            check($sformatf("%s_err%0d", tag, d), int'(err[d]), 0);
            check($sformatf("%s_fv%0d", tag, d), int'(fv[d]), 0);
        end
    endtask

    task automatic launch(input logic [7:0] f);
        @(posedge clk);
        #1;
        f_tbl = f;
        sb0.push_back(model(f, 1, cyc));
        sb1.push_back(model(f, 3, cyc));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run(input logic [7:0] f);
        int t;
        launch(f);
        t = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (sb0.size() != 0 || sb1.size() != 0) begin
            check("done_timeout", 1, 0);
            sb0.delete();
            sb1.delete();
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        bad[0] = 0;
        bad[1] = 0;
        f_tbl  = 8'h80;
        rst    = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("rst");
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("post_rst");

        run(8'h80);
        run(8'hFF);
        run(8'h00);
        for (int i = 0; i < 4; i++) run(8'($urandom));

        // Abort: stuck-at-1 run, ignored STARTs, reset mid-run
        launch(8'hFF);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b1;
        check("abort_err0", int'(err[0]), 3);
        check("abort_err1", int'(err[1]), 3);
        check("abort_busy0", int'(busy[0]), 1);
        sb0.delete();
        sb1.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero("abort");
        repeat (80) @(posedge clk);
        run(8'h80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
